// File: rtl/pmem_arbiter_if.sv
// Bundle of the three sides the arbiter connects: the I-cache and D-cache
// line ports and the 256-bit physical-memory port.
//
// Handshake: a client raises read/write and holds it, with a stable address
// and wdata, until it sees its one-cycle resp. The arbiter then owns the
// memory side. It holds pmem_read or pmem_write, with pmem_address and
// pmem_wdata, until the memory answers with a one-cycle pmem_resp. pmem_rdata
// is valid only while pmem_resp is high.
interface pmem_arbiter_if;
   logic         icache_read;
   logic [15:0]  icache_address;
   logic         icache_resp;
   logic [255:0] icache_rdata;

   logic         dcache_read;
   logic         dcache_write;
   logic [15:0]  dcache_address;
   logic [255:0] dcache_wdata;
   logic         dcache_resp;
   logic [255:0] dcache_rdata;

   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic         pmem_resp;
   logic [255:0] pmem_rdata;

   // Arbiter view: serves the clients and drives the memory.
   modport master (
      input  icache_read, icache_address,
      input  dcache_read, dcache_write, dcache_address, dcache_wdata,
      input  pmem_resp, pmem_rdata,
      output icache_resp, icache_rdata,
      output dcache_resp, dcache_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   // Environment view: the caches and the memory.
   modport slave (
      output icache_read, icache_address,
      output dcache_read, dcache_write, dcache_address, dcache_wdata,
      output pmem_resp, pmem_rdata,
      input  icache_resp, icache_rdata,
      input  dcache_resp, dcache_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter between the I-cache (line reads) and the D-cache (line
// reads and writebacks). Only one memory transaction is outstanding at a time.
// Every completion is followed by one DONE cycle with the strobes low, so the
// memory sees an idle cycle between transactions.
module pmem_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11    // 2**CNT_W must exceed TIMEOUT
) (
   input  logic           clk,
   input  logic           rst,
   pmem_arbiter_if.master bus,
   output logic           timeout_err,
   output logic [1:0]     dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_d;   // 1: the D-cache was granted most recently
   logic [CNT_W-1:0] cnt_q;
   logic             req_i, req_d;
   logic             grant_i, grant_d, complete;

   assign req_i     = bus.icache_read;
   assign req_d     = bus.dcache_read | bus.dcache_write;
   assign dbg_state = state_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and grant/complete decisions. On a tie, grant the client that was not granted last.
   always_comb begin
      state_d  = state_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i && (!req_d || last_grant_d)) begin
               grant_i = 1'b1;
               state_d = SERVE_I;
            end else if (req_d) begin
               grant_d = 1'b1;
               state_d = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (bus.pmem_resp) begin
               complete = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered memory strobes, latched request, client returns and the wait/timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.pmem_read    <= 1'b0;
         bus.pmem_write   <= 1'b0;
         bus.pmem_address <= '0;
         bus.pmem_wdata   <= '0;
         bus.icache_resp  <= 1'b0;
         bus.icache_rdata <= '0;
         bus.dcache_resp  <= 1'b0;
         bus.dcache_rdata <= '0;
         last_grant_d     <= 1'b1;
         cnt_q            <= '0;
         timeout_err      <= 1'b0;
      end else begin
         bus.icache_resp <= 1'b0;
         bus.dcache_resp <= 1'b0;

         if (grant_i) begin
            bus.pmem_address <= bus.icache_address & 16'hFFE0;
            bus.pmem_read    <= 1'b1;
            last_grant_d     <= 1'b0;
            cnt_q            <= '0;
         end

         if (grant_d) begin
            bus.pmem_address <= bus.dcache_address & 16'hFFE0;
            // A read and a write raised together count as a writeback.
            if (bus.dcache_write) begin
               bus.pmem_wdata <= bus.dcache_wdata;
               bus.pmem_write <= 1'b1;
            end else begin
               bus.pmem_read  <= 1'b1;
            end
            last_grant_d <= 1'b1;
            cnt_q        <= '0;
         end

         if (complete) begin
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
            cnt_q          <= '0;
            if (state_q == SERVE_I) begin
               bus.icache_rdata <= bus.pmem_rdata;
               bus.icache_resp  <= 1'b1;
            end else begin
               bus.dcache_rdata <= bus.pmem_rdata;
               bus.dcache_resp  <= 1'b1;
            end
         end else if (state_q == SERVE_I || state_q == SERVE_D) begin
            // The counter saturates at TIMEOUT. A timeout only flags the
            // condition: the transaction keeps waiting for its response.
            if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a short timeout (TIMEOUT=8).
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_pmem_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0, S_SI = 2'd1, S_SD = 2'd2, S_DONE = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic       timeout_err;
   logic [1:0] dbg_state;
   int         n_cmp = 0;
   int         n_err = 0;

   pmem_arbiter_if bus();

   pmem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; read and write strobes must never be high together.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("strobe_excl", 256'(bus.pmem_read & bus.pmem_write), 256'd0);
   endtask

   initial begin
      logic [255:0] line_l, a5, prev_i, prev_d, line_k;
      logic         exp_i;
      line_l = {8{32'hDEAD_BEEF}};
      a5     = {32{8'hA5}};

      rst = 1'b1;
      bus.icache_read = 0; bus.icache_address = '0;
      bus.dcache_read = 0; bus.dcache_write = 0;
      bus.dcache_address = '0; bus.dcache_wdata = '0;
      bus.pmem_resp = 0; bus.pmem_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_state", 256'(dbg_state), 256'(S_IDLE));
      chk("rst_pmem_read", 256'(bus.pmem_read), 256'd0);
      chk("rst_pmem_addr", 256'(bus.pmem_address), 256'd0);
      chk("rst_icache_rdata", bus.icache_rdata, 256'd0);
      chk("rst_dcache_rdata", bus.dcache_rdata, 256'd0);
      chk("rst_timeout", 256'(timeout_err), 256'd0);

      // 1: I-cache read of 0x0043.
      bus.icache_read = 1; bus.icache_address = 16'h0043;
      tick();
      chk("t1_state", 256'(dbg_state), 256'(S_SI));
      chk("t1_read", 256'(bus.pmem_read), 256'd1);
      chk("t1_addr", 256'(bus.pmem_address), 256'h0040);
      tick();
      chk("t1_read_hold", 256'(bus.pmem_read), 256'd1);
      chk("t1_no_resp_yet", 256'(bus.icache_resp), 256'd0);
      bus.pmem_resp = 1; bus.pmem_rdata = line_l;
      tick();
      chk("t1_resp", 256'(bus.icache_resp), 256'd1);
      chk("t1_rdata", bus.icache_rdata, line_l);
      chk("t1_done_state", 256'(dbg_state), 256'(S_DONE));
      chk("t1_done_read", 256'(bus.pmem_read), 256'd0);
      bus.icache_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
      tick();
      chk("t1_resp_pulse", 256'(bus.icache_resp), 256'd0);
      chk("t1_idle", 256'(dbg_state), 256'(S_IDLE));
      chk("t1_rdata_hold", bus.icache_rdata, line_l);

      // 2: D-cache writeback of 0x1FE0, then a read of the same line.
      bus.dcache_write = 1; bus.dcache_address = 16'h1FE0; bus.dcache_wdata = a5;
      tick();
      chk("t2_state", 256'(dbg_state), 256'(S_SD));
      chk("t2_write", 256'(bus.pmem_write), 256'd1);
      chk("t2_read_low", 256'(bus.pmem_read), 256'd0);
      chk("t2_wdata", bus.pmem_wdata, a5);
      chk("t2_addr", 256'(bus.pmem_address), 256'h1FE0);
      bus.pmem_resp = 1;
      tick();
      chk("t2_wr_resp", 256'(bus.dcache_resp), 256'd1);
      chk("t2_write_low", 256'(bus.pmem_write), 256'd0);
      bus.dcache_write = 0; bus.pmem_resp = 0; bus.dcache_wdata = '0;
      tick();
      bus.dcache_read = 1;
      tick();
      chk("t2_rd_read", 256'(bus.pmem_read), 256'd1);
      chk("t2_rd_write_low", 256'(bus.pmem_write), 256'd0);
      bus.pmem_resp = 1; bus.pmem_rdata = a5;
      tick();
      chk("t2_rd_resp", 256'(bus.dcache_resp), 256'd1);
      chk("t2_rd_rdata", bus.dcache_rdata, a5);
      chk("t2_wdata_hold", bus.pmem_wdata, a5);
      bus.dcache_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
      tick();

      // 3: both clients after reset, held high: grants go I, D, I, D.
      rst = 1; tick(); rst = 0;
      prev_i = '0; prev_d = '0;
      bus.icache_read = 1; bus.icache_address = 16'h0123;
      bus.dcache_read = 1; bus.dcache_address = 16'h0245;
      for (int k = 0; k < 4; k++) begin
         exp_i  = (k % 2 == 0);
         line_k = {8{32'h1000_0000 + 32'(k)}};
         tick();
         chk("t3_grant", 256'(dbg_state), exp_i ? 256'(S_SI) : 256'(S_SD));
         chk("t3_addr", 256'(bus.pmem_address), exp_i ? 256'h0120 : 256'h0240);
         chk("t3_read", 256'(bus.pmem_read), 256'd1);
         bus.pmem_resp = 1; bus.pmem_rdata = line_k;
         tick();
         bus.pmem_resp = 0; bus.pmem_rdata = '0;
         if (exp_i) prev_i = line_k;
         else       prev_d = line_k;
         chk("t3_icache_resp", 256'(bus.icache_resp), 256'(exp_i));
         chk("t3_dcache_resp", 256'(bus.dcache_resp), 256'(!exp_i));
         chk("t3_icache_rdata", bus.icache_rdata, prev_i);
         chk("t3_dcache_rdata", bus.dcache_rdata, prev_d);
         if (k == 3) begin
            bus.icache_read = 0; bus.dcache_read = 0;
         end
         tick();
         chk("t3_idle", 256'(dbg_state), 256'(S_IDLE));
         chk("t3_idle_read", 256'(bus.pmem_read), 256'd0);
      end

      // 4: address changes while the D-cache read is being served.
      bus.dcache_read = 1; bus.dcache_address = 16'h0100;
      tick();
      chk("t4_addr_grant", 256'(bus.pmem_address), 256'h0100);
      bus.dcache_address = 16'h0200;
      tick();
      chk("t4_addr_hold1", 256'(bus.pmem_address), 256'h0100);
      tick();
      chk("t4_addr_hold2", 256'(bus.pmem_address), 256'h0100);
      bus.pmem_resp = 1; bus.pmem_rdata = {4{64'h0123_4567_89AB_CDEF}};
      tick();
      chk("t4_resp", 256'(bus.dcache_resp), 256'd1);
      chk("t4_addr_after", 256'(bus.pmem_address), 256'h0100);
      bus.dcache_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
      tick();

      // 5: memory stalls past the timeout, then answers late.
      bus.icache_read = 1; bus.icache_address = 16'h0300;
      tick();
      chk("t5_state", 256'(dbg_state), 256'(S_SI));
      for (int j = 1; j <= 7; j++) tick();
      chk("t5_err_before", 256'(timeout_err), 256'd0);
      tick();
      chk("t5_err_at_8", 256'(timeout_err), 256'd1);
      tick(); tick(); tick();
      chk("t5_err_sticky", 256'(timeout_err), 256'd1);
      chk("t5_still_serving", 256'(dbg_state), 256'(S_SI));
      bus.pmem_resp = 1; bus.pmem_rdata = {16{16'h5A5A}};
      tick();
      chk("t5_late_resp", 256'(bus.icache_resp), 256'd1);
      chk("t5_late_rdata", bus.icache_rdata, {16{16'h5A5A}});
      bus.icache_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
      tick();
      chk("t5_err_idle", 256'(timeout_err), 256'd1);
      rst = 1; tick(); rst = 0;
      chk("t5_err_cleared", 256'(timeout_err), 256'd0);

      // 6: reset in the middle of an I-cache read; its response arrives as a stray.
      bus.icache_read = 1; bus.icache_address = 16'h0400;
      tick();
      chk("t6_read", 256'(bus.pmem_read), 256'd1);
      tick();
      rst = 1; bus.icache_read = 0;
      tick();
      rst = 0;
      chk("t6_rst_state", 256'(dbg_state), 256'(S_IDLE));
      chk("t6_rst_read", 256'(bus.pmem_read), 256'd0);
      for (int j = 0; j < 4; j++) tick();
      bus.pmem_resp = 1; bus.pmem_rdata = {8{32'hCAFE_F00D}};
      tick();
      chk("t6_stray_resp", 256'(bus.icache_resp), 256'd0);
      chk("t6_stray_rdata", bus.icache_rdata, 256'd0);
      chk("t6_stray_state", 256'(dbg_state), 256'(S_IDLE));
      bus.pmem_resp = 0; bus.pmem_rdata = '0;
      bus.icache_read = 1; bus.icache_address = 16'h0500;
      tick();
      chk("t6_new_state", 256'(dbg_state), 256'(S_SI));
      chk("t6_new_addr", 256'(bus.pmem_address), 256'h0500);
      bus.pmem_resp = 1; bus.pmem_rdata = {8{32'h7777_0001}};
      tick();
      chk("t6_new_resp", 256'(bus.icache_resp), 256'd1);
      chk("t6_new_rdata", bus.icache_rdata, {8{32'h7777_0001}});
      bus.icache_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
